// File: rtl/stop_watch_lap.sv
// Purpose: m:ss.t BCD stopwatch/timer with preload, lap freeze and terminal-event pulses.
// Latency: digits update on the clock edge that carries a tick; done/wrap pulse alongside the new digits.
// Backpressure: none; go=0 pauses the divider and digits, and a down-count parks at 0:00.0.
module stop_watch_lap #(
  parameter int DVSR    = 10000000,
  parameter int DW      = 24,
  parameter int MIN_MAX = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        clr,
  input  logic        down,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        lap,
  output logic [3:0]  d3,
  output logic [3:0]  d2,
  output logic [3:0]  d1,
  output logic [3:0]  d0,
  output logic        lap_active,
  output logic        done,
  output logic        wrap,
  output logic        running
);

  localparam logic [DW-1:0] TERM    = DW'(DVSR - 1);
  localparam logic [DW-1:0] DIV_ONE = DW'(1);
  localparam logic [3:0]    MM      = 4'(MIN_MAX);

  logic [DW-1:0] div_q, div_n;
  logic          tick;
  logic [3:0]    min_q, sten_q, sunit_q, tenth_q;
  logic [3:0]    min_n, sten_n, sunit_n, tenth_n;
  logic [15:0]   lap_q;
  logic          lap_active_q;
  logic          done_q, wrap_q;
  logic          is_zero, is_top, is_one;

  // Clamp a preload nibble into its digit range.
  function automatic logic [3:0] sat(input logic [3:0] v, input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  assign is_zero = ({min_q, sten_q, sunit_q, tenth_q} == 16'h0000);
  assign is_one  = ({min_q, sten_q, sunit_q, tenth_q} == 16'h0001);
  assign is_top  = (min_q == MM) && (sten_q == 4'd5) && (sunit_q == 4'd9) && (tenth_q == 4'd9);

  // Tick fires on the last divider count; a down-count parked at zero never ticks.
  always_comb begin
    tick = go && !clr && !load && !(down && is_zero) && (div_q == TERM);
  end

  // Divider next value: cleared by clr/load, held at zero while a timer sits at 0:00.0.
  always_comb begin
    div_n = div_q;
    if (clr || load) begin
      div_n = '0;
    end else if (go) begin
      if ((down && is_zero) || (div_q == TERM)) div_n = '0;
      else                                      div_n = div_q + DIV_ONE;
    end
  end

  // Digit next value: clr > load > tick, with BCD carry/borrow chains.
  always_comb begin
    min_n   = min_q;
    sten_n  = sten_q;
    sunit_n = sunit_q;
    tenth_n = tenth_q;
    if (clr) begin
      min_n   = 4'd0;
      sten_n  = 4'd0;
      sunit_n = 4'd0;
      tenth_n = 4'd0;
    end else if (load) begin
      min_n   = sat(load_val[15:12], MM);
      sten_n  = sat(load_val[11:8], 4'd5);
      sunit_n = sat(load_val[7:4], 4'd9);
      tenth_n = sat(load_val[3:0], 4'd9);
    end else if (tick && !down) begin
      if (tenth_q == 4'd9) begin
        tenth_n = 4'd0;
        if (sunit_q == 4'd9) begin
          sunit_n = 4'd0;
          if (sten_q == 4'd5) begin
            sten_n = 4'd0;
            min_n  = (min_q >= MM) ? 4'd0 : min_q + 4'd1;
          end else begin
            sten_n = sten_q + 4'd1;
          end
        end else begin
          sunit_n = sunit_q + 4'd1;
        end
      end else begin
        tenth_n = tenth_q + 4'd1;
      end
    end else if (tick && down) begin
      // is_zero is excluded by tick, so the minute borrow never underflows.
      if (tenth_q == 4'd0) begin
        tenth_n = 4'd9;
        if (sunit_q == 4'd0) begin
          sunit_n = 4'd9;
          if (sten_q == 4'd0) begin
            sten_n = 4'd5;
            min_n  = min_q - 4'd1;
          end else begin
            sten_n = sten_q - 4'd1;
          end
        end else begin
          sunit_n = sunit_q - 4'd1;
        end
      end else begin
        tenth_n = tenth_q - 4'd1;
      end
    end
  end

  // Divider and live digit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      min_q   <= 4'd0;
      sten_q  <= 4'd0;
      sunit_q <= 4'd0;
      tenth_q <= 4'd0;
    end else begin
      div_q   <= div_n;
      min_q   <= min_n;
      sten_q  <= sten_n;
      sunit_q <= sunit_n;
      tenth_q <= tenth_n;
    end
  end

  // Terminal-event pulses, raised by the tick that reaches the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      done_q <= tick && down && is_one;
      wrap_q <= tick && !down && is_top;
    end
  end

  // Lap freeze: first lap captures the pre-tick live digits, second lap releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q        <= 16'h0000;
      lap_active_q <= 1'b0;
    end else if (clr) begin
      lap_q        <= 16'h0000;
      lap_active_q <= 1'b0;
    end else if (lap) begin
      if (!lap_active_q) begin
        lap_q        <= {min_q, sten_q, sunit_q, tenth_q};
        lap_active_q <= 1'b1;
      end else begin
        lap_active_q <= 1'b0;
      end
    end
  end

  // Display mux selects frozen lap digits or live digits; both sides are registers.
  always_comb begin
    {d3, d2, d1, d0} = lap_active_q ? lap_q : {min_q, sten_q, sunit_q, tenth_q};
    lap_active       = lap_active_q;
    done             = done_q;
    wrap             = wrap_q;
    running          = go && !(down && is_zero);
  end

endmodule

// File: tb/tb_stop_watch_lap.sv
// Directed bench: two instances (MIN_MAX=9 and MIN_MAX=1, DVSR=4) share one stimulus stream.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Expected values are hand-computed constants for each step.
module tb_stop_watch_lap;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        go = 1'b0;
  logic        clr = 1'b0;
  logic        down = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic        lap = 1'b0;

  logic [3:0] a_d3, a_d2, a_d1, a_d0;
  logic       a_lap_active, a_done, a_wrap, a_running;
  logic [3:0] b_d3, b_d2, b_d1, b_d0;
  logic       b_lap_active, b_done, b_wrap, b_running;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  stop_watch_lap #(.DVSR(4), .DW(4), .MIN_MAX(9)) u_a (
    .clk(clk), .rst_n(rst_n), .go(go), .clr(clr), .down(down), .load(load),
    .load_val(load_val), .lap(lap),
    .d3(a_d3), .d2(a_d2), .d1(a_d1), .d0(a_d0),
    .lap_active(a_lap_active), .done(a_done), .wrap(a_wrap), .running(a_running)
  );

  stop_watch_lap #(.DVSR(4), .DW(4), .MIN_MAX(1)) u_b (
    .clk(clk), .rst_n(rst_n), .go(go), .clr(clr), .down(down), .load(load),
    .load_val(load_val), .lap(lap),
    .d3(b_d3), .d2(b_d2), .d1(b_d1), .d0(b_d0),
    .lap_active(b_lap_active), .done(b_done), .wrap(b_wrap), .running(b_running)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] disp_a();
    return {a_d3, a_d2, a_d1, a_d0};
  endfunction

  function automatic logic [15:0] disp_b();
    return {b_d3, b_d2, b_d1, b_d0};
  endfunction

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_digits", 32'(disp_a()), 32'h0000);
    chk("rst_flags", {28'h0, a_lap_active, a_done, a_wrap, a_running}, 32'h0);
    #3 rst_n = 1'b1;
    step(1);

    // First tick DVSR edges after go from a cleared state
    go = 1'b1;
    step(3);
    chk("pre_first_tick", 32'(disp_a()), 32'h0000);
    chk("running_up", 32'(a_running), 32'h1);
    step(1);
    chk("first_tick", 32'(disp_a()), 32'h0001);
    step(6);
    chk("two_ticks", 32'(disp_a()), 32'h0002);

    // Async reset mid-count, then resume from zero
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 32'(disp_a()), 32'h0000);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_pre_tick", 32'(disp_a()), 32'h0000);
    step(1);
    chk("post_rst_tick", 32'(disp_a()), 32'h0001);

    // Up wrap: B (MIN_MAX=1) wraps at 1:59.9, A carries into 2:00.0
    load = 1'b1; load_val = 16'h1598;
    step(1);
    load = 1'b0;
    chk("load_1598_a", 32'(disp_a()), 32'h1598);
    chk("load_1598_b", 32'(disp_b()), 32'h1598);
    step(4);
    chk("up_1599_b", 32'(disp_b()), 32'h1599);
    step(4);
    chk("carry_2000_a", 32'(disp_a()), 32'h2000);
    chk("wrap_none_a", 32'(a_wrap), 32'h0);
    chk("wrap_0000_b", 32'(disp_b()), 32'h0000);
    chk("wrap_pulse_b", {30'h0, b_wrap, b_done}, 32'h2);
    step(1);
    chk("wrap_drop_b", 32'(b_wrap), 32'h0);

    // A wraps at 9:59.9; B saturates the preload minute to 1
    load = 1'b1; load_val = 16'h9598;
    step(1);
    load = 1'b0;
    chk("load_9598_a", 32'(disp_a()), 32'h9598);
    chk("load_sat_min_b", 32'(disp_b()), 32'h1598);
    step(8);
    chk("wrap_0000_a", 32'(disp_a()), 32'h0000);
    chk("wrap_pulse_a", {30'h0, a_wrap, a_done}, 32'h2);
    step(1);
    chk("wrap_drop_a", 32'(a_wrap), 32'h0);

    // Down-count from 0:01.0 to 0:00.0
    down = 1'b1; load = 1'b1; load_val = 16'h0010;
    step(1);
    load = 1'b0;
    chk("load_0010", 32'(disp_a()), 32'h0010);
    chk("load_no_done", 32'(a_done), 32'h0);
    step(4);
    chk("down_0009", 32'(disp_a()), 32'h0009);
    step(36);
    chk("down_0000", 32'(disp_a()), 32'h0000);
    chk("done_pulse_a", {30'h0, a_done, a_running}, 32'h2);
    chk("done_pulse_b", 32'(b_done), 32'h1);
    step(1);
    chk("done_drop", 32'(a_done), 32'h0);
    step(50);
    chk("down_hold", 32'(disp_a()), 32'h0000);
    chk("down_hold_flags", {30'h0, a_done, a_running}, 32'h0);

    // Per-digit saturation, then clr overriding a same-cycle load
    down = 1'b0; load = 1'b1; load_val = 16'hFAFC;
    step(1);
    chk("sat_a", 32'(disp_a()), 32'h9599);
    chk("sat_b", 32'(disp_b()), 32'h1599);
    clr = 1'b1;
    step(1);
    clr = 1'b0; load = 1'b0;
    chk("clr_over_load", 32'(disp_a()), 32'h0000);

    // Lap coincident with a tick freezes the pre-tick value
    load = 1'b1; load_val = 16'h0123;
    step(1);
    load = 1'b0;
    step(3);
    chk("pre_lap", 32'(disp_a()), 32'h0123);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    chk("lap_freeze", 32'(disp_a()), 32'h0123);
    chk("lap_active_on", 32'(a_lap_active), 32'h1);
    step(76);
    chk("lap_still_frozen", 32'(disp_a()), 32'h0123);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    chk("lap_release", 32'(disp_a()), 32'h0143);
    chk("lap_active_off", 32'(a_lap_active), 32'h0);

    // clr beats a same-cycle lap
    lap = 1'b1; clr = 1'b1;
    step(1);
    lap = 1'b0; clr = 1'b0;
    chk("clr_lap", {15'h0, a_lap_active, disp_a()}, 32'h0);

    // Pause for 7 cycles mid-period, then switch direction mid-period
    load = 1'b1; load_val = 16'h0500;
    step(1);
    load = 1'b0;
    step(2);
    go = 1'b0;
    step(7);
    chk("pause_hold", 32'(disp_a()), 32'h0500);
    chk("pause_running", 32'(a_running), 32'h0);
    go = 1'b1;
    step(1);
    chk("resume_no_tick", 32'(disp_a()), 32'h0500);
    down = 1'b1;
    step(1);
    chk("dir_change_tick", 32'(disp_a()), 32'h0499);
    step(3);
    chk("dir_pre_next", 32'(disp_a()), 32'h0499);
    step(1);
    chk("dir_next_tick", 32'(disp_a()), 32'h0498);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Watchdog keeps the run bounded even if the stimulus stalls.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
